// File: rtl/seq_div.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Optional SEQ_DIV_DZ_FLAG_EN adds a registered div_zero result flag.
module seq_div #(
    parameter int DW = 10,
    parameter int VW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder
`ifdef SEQ_DIV_DZ_FLAG_EN
    ,
    output logic          div_zero
`endif
);

    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [VW:0]   prem, prem_n;
    logic [DW-1:0] shreg, shreg_n;
    logic [VW-1:0] dvs, dvs_n;
    logic [DW-1:0] quotient_n;
    logic [VW-1:0] remainder_n;
    logic [VW:0]   trial;
    logic          fits;
`ifdef SEQ_DIV_DZ_FLAG_EN
    logic          dz_n;
`endif

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        prem_n      = prem;
        shreg_n     = shreg;
        dvs_n       = dvs;
        quotient_n  = quotient;
        remainder_n = remainder;
`ifdef SEQ_DIV_DZ_FLAG_EN
        dz_n        = div_zero;
`endif
        // shifted partial remainder; prem < divisor so the MSB drop is lossless
        trial = (prem << 1) | {{VW{1'b0}}, shreg[DW-1]};
        fits  = trial >= {1'b0, dvs};

        unique case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (start) begin
                    dvs_n   = divisor;
                    cnt_n   = '0;
                    prem_n  = '0;
                    shreg_n = dividend;
                    if (divisor != '0) begin
                        state_n = RUN;
                    end else begin
                        state_n     = DONE;
                        quotient_n  = '1;
                        remainder_n = dividend[VW-1:0];
`ifdef SEQ_DIV_DZ_FLAG_EN
                        dz_n        = 1'b1;
`endif
                    end
                end
            end
            RUN: begin
                prem_n  = fits ? trial - {1'b0, dvs} : trial;
                // dividend bits leave at the top, quotient bits enter at the bottom
                shreg_n = {shreg[DW-2:0], fits};
                cnt_n   = cnt + 1'b1;
                if (cnt == CW'(DW - 1)) begin
                    state_n     = DONE;
                    quotient_n  = shreg_n;
                    remainder_n = prem_n[VW-1:0];
`ifdef SEQ_DIV_DZ_FLAG_EN
                    dz_n        = 1'b0;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            prem      <= '0;
            shreg     <= '0;
            dvs       <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef SEQ_DIV_DZ_FLAG_EN
            div_zero  <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            prem      <= prem_n;
            shreg     <= shreg_n;
            dvs       <= dvs_n;
            quotient  <= quotient_n;
            remainder <= remainder_n;
`ifdef SEQ_DIV_DZ_FLAG_EN
            div_zero  <= dz_n;
`endif
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div: latency, results, back-to-back,
// divide-by-zero, ignored start and mid-run reset.
module tb_seq_div;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [9:0] dividend;
    logic [4:0] divisor;
    logic       busy;
    logic       done;
    logic [9:0] quotient;
    logic [4:0] remainder;
`ifdef SEQ_DIV_DZ_FLAG_EN
    logic       div_zero;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    seq_div #(.DW(10), .VW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef SEQ_DIV_DZ_FLAG_EN
        ,
        .div_zero  (div_zero)
`endif
    );

    always #5 clk = ~clk;

    // Called at a negedge; the following posedge accepts the request.
    task automatic launch(input logic [9:0] a, input logic [4:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat = rising edges after the accepting edge until done is seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00", {busy, done});
        end
        n_cmp++;
        if (quotient !== 10'd0 || remainder !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_result: got %0d r%0d want 0 r0",
                     quotient, remainder);
        end
`ifdef SEQ_DIV_DZ_FLAG_EN
        n_cmp++;
        if (div_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_dz: got %b want 0", div_zero);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat, bcnt;
        @(negedge clk);
        launch(10'd625, 5'd25);
        wait_done(lat, bcnt);
        n_cmp++;
        if (lat !== 10 || bcnt !== 10) begin
            n_bad++;
            $display("FAIL basic_timing: got lat %0d busy %0d want 10 10",
                     lat, bcnt);
        end
        n_cmp++;
        if (quotient !== 10'd25 || remainder !== 5'd0) begin
            n_bad++;
            $display("FAIL basic_result: got %0d r%0d want 25 r0",
                     quotient, remainder);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || quotient !== 10'd25) begin
            n_bad++;
            $display("FAIL basic_pulse: got done %b q %0d want 0 25",
                     done, quotient);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        @(negedge clk);
        launch(10'd1023, 5'd1);
        wait_done(lat, bcnt);
        n_cmp++;
        if (quotient !== 10'd1023 || remainder !== 5'd0 || lat !== 10) begin
            n_bad++;
            $display("FAIL max_result: got %0d r%0d lat %0d want 1023 r0 10",
                     quotient, remainder, lat);
        end
        launch(10'd1000, 5'd31);
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0 || quotient !== 10'd1023) begin
            n_bad++;
            $display("FAIL b2b_accept: got busy %b done %b q %0d want 1 0 1023",
                     busy, done, quotient);
        end
        wait_done(lat, bcnt);
        n_cmp++;
        if (lat !== 10 || bcnt !== 10) begin
            n_bad++;
            $display("FAIL b2b_timing: got lat %0d busy %0d want 10 10",
                     lat, bcnt);
        end
        n_cmp++;
        if (quotient !== 10'd32 || remainder !== 5'd8) begin
            n_bad++;
            $display("FAIL b2b_result: got %0d r%0d want 32 r8",
                     quotient, remainder);
        end
    endtask

    task automatic test_small;
        int lat, bcnt;
        @(negedge clk);
        launch(10'd7, 5'd31);
        wait_done(lat, bcnt);
        n_cmp++;
        if (quotient !== 10'd0 || remainder !== 5'd7 || lat !== 10) begin
            n_bad++;
            $display("FAIL small_7_31: got %0d r%0d lat %0d want 0 r7 10",
                     quotient, remainder, lat);
        end
        @(negedge clk);
        launch(10'd0, 5'd5);
        wait_done(lat, bcnt);
        n_cmp++;
        if (quotient !== 10'd0 || remainder !== 5'd0 || lat !== 10) begin
            n_bad++;
            $display("FAIL small_0_5: got %0d r%0d lat %0d want 0 r0 10",
                     quotient, remainder, lat);
        end
    endtask

    task automatic test_div_zero;
        int lat, bcnt;
        @(negedge clk);
        launch(10'd100, 5'd0);
        wait_done(lat, bcnt);
        n_cmp++;
        if (lat !== 0 || bcnt !== 0) begin
            n_bad++;
            $display("FAIL dz_timing: got lat %0d busy %0d want 0 0",
                     lat, bcnt);
        end
        n_cmp++;
        if (quotient !== 10'd1023 || remainder !== 5'd4) begin
            n_bad++;
            $display("FAIL dz_result: got %0d r%0d want 1023 r4",
                     quotient, remainder);
        end
`ifdef SEQ_DIV_DZ_FLAG_EN
        n_cmp++;
        if (div_zero !== 1'b1) begin
            n_bad++;
            $display("FAIL dz_flag_set: got %b want 1", div_zero);
        end
`endif
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== 10'd1023) begin
            n_bad++;
            $display("FAIL dz_pulse: got done %b busy %b q %0d want 0 0 1023",
                     done, busy, quotient);
        end
        launch(10'd1000, 5'd31);
        wait_done(lat, bcnt);
        n_cmp++;
        if (quotient !== 10'd32 || remainder !== 5'd8) begin
            n_bad++;
            $display("FAIL dz_next: got %0d r%0d want 32 r8",
                     quotient, remainder);
        end
`ifdef SEQ_DIV_DZ_FLAG_EN
        n_cmp++;
        if (div_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL dz_flag_clr: got %b want 0", div_zero);
        end
`endif
    endtask

    task automatic test_start_ignored;
        int lat, bcnt;
        @(negedge clk);
        launch(10'd625, 5'd25);
        repeat (3) @(negedge clk);
        launch(10'd1000, 5'd3);
        wait_done(lat, bcnt);
        n_cmp++;
        if (lat + 4 !== 10) begin
            n_bad++;
            $display("FAIL ign_timing: got lat %0d want 10", lat + 4);
        end
        n_cmp++;
        if (quotient !== 10'd25 || remainder !== 5'd0) begin
            n_bad++;
            $display("FAIL ign_result: got %0d r%0d want 25 r0",
                     quotient, remainder);
        end
    endtask

    task automatic test_reset_abort;
        bit saw_done;
        @(negedge clk);
        launch(10'd625, 5'd25);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL abort_flags: got %b want 00", {busy, done});
        end
        n_cmp++;
        if (quotient !== 10'd0 || remainder !== 5'd0) begin
            n_bad++;
            $display("FAIL abort_result: got %0d r%0d want 0 r0",
                     quotient, remainder);
        end
        saw_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_quiet: got activity %b want 0", saw_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_small();
        test_div_zero();
        test_start_ignored();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
